// File: rtl/sc_et_ctrl_if.sv
// rtl/sc_et_ctrl_if.sv - request/result bundle of the early-termination scheduler
//
// Purpose: groups the evaluation request (start/config) and the result
// (status, counts, decision) signals of sc_et_ctrl.
// Signals:
//   start, ready          request handshake (ready high only while idle)
//   bp_cfg, len_cfg,      configuration, sampled on the accepting edge
//   thresh, et_en
//   busy, done            run status; done is a one-cycle pulse
//   ones, cycles          ones accumulated / RUN cycles consumed
//   decision, early       threshold result and early-termination flag
// Modports: master = requester side, slave = scheduler side.
interface sc_et_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] bp_cfg;
  logic [WIDTH:0]   len_cfg;
  logic [WIDTH:0]   thresh;
  logic             et_en;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   ones;
  logic [WIDTH:0]   cycles;
  logic             decision;
  logic             early;

  modport master (
    output start, bp_cfg, len_cfg, thresh, et_en,
    input  ready, busy, done, ones, cycles, decision, early
  );

  modport slave (
    input  start, bp_cfg, len_cfg, thresh, et_en,
    output ready, busy, done, ones, cycles, decision, early
  );
endinterface

// File: rtl/sc_et_ctrl.sv
// rtl/sc_et_ctrl.sv - early-termination scheduler for one stochastic-computing evaluation
//
// Purpose: accepts a start request, clears and enables the bypass counter,
// accumulates ones of the SC output stream and stops as soon as the
// threshold decision is settled, the stream length is reached or the
// counter overflows. The result is reported with a one-cycle done pulse.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        sc_et_ctrl_if.slave: start/ready, config, status and result
//   ctr_clr    clear strobe to the bypass counter (LOAD)
//   ctr_en     count enable to the bypass counter (RUN)
//   ctr_bp     latched bypass mask to the counter
//   ctr_ovf    counter overflow
//   sc_bit     SC output bit, valid while ctr_en=1
module sc_et_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  sc_et_ctrl_if.slave      bus,
  output logic             ctr_clr,
  output logic             ctr_en,
  output logic [WIDTH-1:0] ctr_bp,
  input  logic             ctr_ovf,
  input  logic             sc_bit
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] bp_q;
  logic [WIDTH:0]   len_q;
  logic [WIDTH:0]   thr_q;
  logic             et_q;
  logic [WIDTH:0]   ones_q;
  logic [WIDTH:0]   cycles_q;
  logic             dec_q;
  logic             early_q;

  logic [WIDTH:0]   ones_n;
  logic [WIDTH:0]   cycles_n;
  logic [WIDTH+1:0] reach_n;
  logic             pass, fail, end_len, end_any;

  // Counts as they will be after the current RUN cycle; all termination
  // rules look at these so the stop takes effect without a lag cycle.
  assign ones_n   = ones_q + {{WIDTH{1'b0}}, sc_bit};
  assign cycles_n = cycles_q + {{WIDTH{1'b0}}, 1'b1};
  // Best reachable ones count; one extra bit so ones_n + remaining never wraps.
  assign reach_n  = {1'b0, ones_n} + {1'b0, len_q} - {1'b0, cycles_n};
  assign pass     = et_q & (ones_n >= thr_q);
  assign fail     = et_q & (reach_n < {1'b0, thr_q});
  assign end_len  = (cycles_n == len_q);
  assign end_any  = pass | fail | end_len | ctr_ovf;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = LOAD;
      LOAD: state_nx = (len_q == '0) ? DONE : RUN;
      RUN:  if (end_any) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
    bus.busy  = (state == LOAD) || (state == RUN);
    bus.done  = (state == DONE);
    ctr_clr   = (state == LOAD);
    ctr_en    = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q     <= '0;
      len_q    <= '0;
      thr_q    <= '0;
      et_q     <= 1'b0;
      ones_q   <= '0;
      cycles_q <= '0;
      dec_q    <= 1'b0;
      early_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          bp_q     <= bus.bp_cfg;
          len_q    <= bus.len_cfg;
          thr_q    <= bus.thresh;
          et_q     <= bus.et_en;
          ones_q   <= '0;
          cycles_q <= '0;
          dec_q    <= 1'b0;
          early_q  <= 1'b0;
        end
        // Zero-length run never enters RUN: the decision is settled
        // with zero ones. Overwritten by RUN otherwise.
        LOAD: dec_q <= (thr_q == '0);
        RUN: begin
          ones_q   <= ones_n;
          cycles_q <= cycles_n;
          dec_q    <= (ones_n >= thr_q);
          early_q  <= (pass | fail) & ~end_len & ~ctr_ovf;
        end
        default: ;
      endcase
    end
  end

  assign ctr_bp       = bp_q;
  assign bus.ones     = ones_q;
  assign bus.cycles   = cycles_q;
  assign bus.decision = dec_q;
  assign bus.early    = early_q;

endmodule
